// File: rtl/ibex_pkg.sv
// Shared types for the instruction aligner: halfword FIFO entry and capacity constants.
package ibex_pkg;

    typedef struct packed {
        logic [15:0] data;
        logic        err;
    } hw_entry_t;

    localparam int unsigned HwEntryW     = $bits(hw_entry_t);
    localparam int unsigned AlignerMaxHw = 8;
    localparam int unsigned AlignerCntW  = 4;

endpackage

// File: rtl/ibex_instr_aligner_fifo.sv
// Halfword FIFO with head at slot 0; accepts 0/1/2 pushes and 0/1/2 pops per cycle.
module ibex_instr_aligner_fifo
    import ibex_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic [1:0]             push_cnt_i,
    input  logic [HwEntryW-1:0]    push_lo_i,
    input  logic [HwEntryW-1:0]    push_hi_i,
    input  logic [1:0]             pop_cnt_i,
    output logic [HwEntryW-1:0]    head_o,
    output logic [HwEntryW-1:0]    next_o,
    output logic [AlignerCntW-1:0] count_o
);

    localparam int unsigned NumHw = 2 * Depth;

    hw_entry_t              mem_q [NumHw];
    hw_entry_t              mem_d [NumHw];
    logic [AlignerCntW-1:0] count_q, count_d;

    // Shift out popped entries, then write new ones just past the surviving data.
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < NumHw; i++) begin
            for (int p = 1; p <= 2; p++) begin
                if ((int'(pop_cnt_i) == p) && (i + p < NumHw)) begin
                    mem_d[i] = mem_q[i+p];
                end
            end
            if ((push_cnt_i != 2'd0) && (i == int'(count_q) - int'(pop_cnt_i))) begin
                mem_d[i] = hw_entry_t'(push_lo_i);
            end
            if ((push_cnt_i == 2'd2) && (i == int'(count_q) - int'(pop_cnt_i) + 1)) begin
                mem_d[i] = hw_entry_t'(push_hi_i);
            end
        end
        if (clear_i) begin
            count_d = '0;
        end else begin
            count_d = count_q + {2'b00, push_cnt_i} - {2'b00, pop_cnt_i};
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[0];
    assign next_o  = mem_q[1];
    assign count_o = count_q;

endmodule

// File: rtl/ibex_instr_aligner.sv
// Realigns word fetches into 16/32-bit instructions with their addresses.
// Define IBEX_ALIGNER_FETCH_ERR_EN to carry fetch bus errors through to out_err_o.
module ibex_instr_aligner
    import ibex_pkg::*;
#(
    parameter int unsigned Depth     = 2,
    parameter bit          CHERIoTEn = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic [31:0] flush_addr_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_rdata_i,
    input  logic        in_err_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_instr_o,
    output logic        out_is_compressed_o,
    output logic        out_err_o,
    output logic [31:0] out_addr_o
);

    localparam int unsigned NumHw = 2 * Depth;
    localparam bit unused_cheriot = CHERIoTEn;

    logic [AlignerCntW-1:0] count;
    logic [HwEntryW-1:0]    head_raw, next_raw;
    hw_entry_t              head, next_hw, push_lo, push_hi;
    logic [1:0]             push_cnt, pop_cnt;
    logic                   skip_q, skip_d;
    logic [31:0]            addr_q, addr_d;
    logic                   push, pop, valid, err_in, err_any;
    logic                   head_present, next_present, uncomp;
    logic [15:0]            next_data;
    logic                   unused_sigs;

    assign head    = hw_entry_t'(head_raw);
    assign next_hw = hw_entry_t'(next_raw);

    assign in_ready_o   = count <= AlignerCntW'(NumHw - 2);
    assign push         = in_valid_i & in_ready_o & ~flush_i;
    assign head_present = count != '0;
    assign next_present = count >= AlignerCntW'(2);
    assign uncomp       = head.data[1:0] == 2'b11;
    assign next_data    = next_present ? next_hw.data : 16'h0000;

`ifdef IBEX_ALIGNER_FETCH_ERR_EN
    assign err_in  = in_err_i;
    // An errored head is released alone so the core can take the fetch fault.
    assign valid   = ~flush_i & head_present & (~uncomp | next_present | head.err);
    assign err_any = head.err | (uncomp & next_present & next_hw.err);
    assign unused_sigs = flush_addr_i[0];
`else
    assign err_in  = 1'b0;
    assign valid   = ~flush_i & head_present & (~uncomp | next_present);
    assign err_any = 1'b0;
    assign unused_sigs = ^{flush_addr_i[0], in_err_i, head.err, next_hw.err};
`endif

    always_comb begin
        push_lo  = '{data: in_rdata_i[15:0], err: err_in};
        push_hi  = '{data: in_rdata_i[31:16], err: err_in};
        push_cnt = 2'd0;
        if (push) begin
            if (skip_q) begin
                push_cnt = 2'd1;
                push_lo  = push_hi;
            end else begin
                push_cnt = 2'd2;
            end
        end
    end

    assign pop = valid & out_ready_i;

    always_comb begin
        pop_cnt = 2'd0;
        if (pop) begin
            pop_cnt = (uncomp & next_present) ? 2'd2 : 2'd1;
        end
    end

    always_comb begin
        addr_d = addr_q;
        skip_d = skip_q;
        if (flush_i) begin
            addr_d = {flush_addr_i[31:1], 1'b0};
            skip_d = flush_addr_i[1];
        end else begin
            if (pop) begin
                addr_d = addr_q + (uncomp ? 32'd4 : 32'd2);
            end
            if (push) begin
                skip_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q <= '0;
            skip_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            skip_q <= skip_d;
        end
    end

    ibex_instr_aligner_fifo #(
        .Depth(Depth)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (flush_i),
        .push_cnt_i(push_cnt),
        .push_lo_i (push_lo),
        .push_hi_i (push_hi),
        .pop_cnt_i (pop_cnt),
        .head_o    (head_raw),
        .next_o    (next_raw),
        .count_o   (count)
    );

    assign out_valid_o         = valid;
    assign out_instr_o         = !valid ? 32'h0 :
                                 uncomp ? {next_data, head.data} : {16'h0000, head.data};
    assign out_is_compressed_o = out_instr_o[1:0] != 2'b11;
    assign out_err_o           = valid & err_any;
    assign out_addr_o          = addr_q;

endmodule
